// File: rtl/onehot_enc_32_5_seq_pkg.sv
// Shared types and defaults for the 32->5 sequential request encoder family.
// No logic lives here.
// State encoding and the default widths live here.
package onehot_enc_32_5_seq_pkg;

    localparam int ENC_N  = 32;
    localparam int ENC_W  = 5;
    localparam int ENC_CW = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_enc_32_5_seq_if.sv
// Request-vector input stream and index output stream of the encoder.
// Wiring only, so there is no latency.
// The valid/ready pairs carry the backpressure in both directions.
interface onehot_enc_32_5_seq_if
    import onehot_enc_32_5_seq_pkg::*;
#(
    parameter int N  = ENC_N,
    parameter int W  = ENC_W,
    parameter int CW = ENC_CW
);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_idx;
    logic          out_last;
    logic [CW-1:0] remain;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  remain
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output remain
    );

endinterface

// File: rtl/onehot_enc_32_5_seq_penc_lsb.sv
// Lowest-set-bit priority encoder. It returns the index of the lowest set bit and a none flag.
// Purely combinational, so the latency is zero.
// It has no handshake and no backpressure.
module penc_lsb
    import onehot_enc_32_5_seq_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         none
);

    // Scan from the top down so the lowest set bit is the one written last.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx  = W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/onehot_enc_32_5_seq.sv
// Sequential request encoder. It emits the index of each set bit of a vector, lowest first.
// A vector accepted at edge T gives its first beat in the next cycle; in_ready returns one cycle after the last beat.
// While out_ready is low the outputs hold; no new vector is taken until every pending bit has drained.
module onehot_enc_32_5_seq
    import onehot_enc_32_5_seq_pkg::*;
#(
    parameter int N  = ENC_N,
    parameter int W  = ENC_W,
    parameter int CW = ENC_CW
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_enc_32_5_seq_if.slave  bus
);

    state_t        state, state_nxt;
    logic [N-1:0]  pend, pend_nxt;
    logic [CW-1:0] remain, remain_nxt;

    logic [W-1:0]  low_idx;
    logic          low_none;
    logic [N-1:0]  one_v;
    logic [N-1:0]  clr_mask;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    penc_lsb #(.N(N), .W(W)) u_penc (
        .vec  (pend),
        .idx  (low_idx),
        .none (low_none)
    );

    assign one_v    = N'(1);
    assign clr_mask = low_none ? '1 : ~(one_v << low_idx);

    // All outputs come from registered state; rst reaches in_ready only.
    assign bus.in_ready  = (state == ST_IDLE) & ~rst;
    assign bus.out_valid = (state == ST_EMIT) & ~low_none;
    assign bus.out_idx   = low_idx;
    assign bus.out_last  = (state == ST_EMIT) & (remain == CW'(1));
    assign bus.remain    = remain;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            pend   <= '0;
            remain <= '0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            remain <= remain_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        remain_nxt = remain;
        case (state)
            ST_IDLE: begin
                // A zero vector is accepted and dropped without leaving IDLE.
                if (bus.in_valid && bus.in_vec != '0) begin
                    pend_nxt   = bus.in_vec;
                    remain_nxt = popcount(bus.in_vec);
                    state_nxt  = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready && !low_none) begin
                    pend_nxt   = pend & clr_mask;
                    remain_nxt = remain - CW'(1);
                    if (remain == CW'(1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                pend_nxt   = '0;
                remain_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_onehot_enc_32_5_seq.sv
// Scoreboard bench for onehot_enc_32_5_seq: random and directed vectors are checked against a bit-walk model.
module tb_onehot_enc_32_5_seq;
    import onehot_enc_32_5_seq_pkg::*;

    typedef struct {
        int idx;
        int last;
        int rem;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    onehot_enc_32_5_seq_if #(.N(32), .W(5), .CW(6)) bus ();

    onehot_enc_32_5_seq #(.N(32), .W(5), .CW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    rnd_ready   = 1'b0;
    bit    ready_force = 1'b1;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // The model walks the vector's bits in ascending order; remain counts down from the popcount.
    task automatic push_vec(input logic [31:0] v);
        int    cnt;
        beat_t b;
        cnt = 0;
        for (int i = 0; i < 32; i++) if (v[i]) cnt++;
        for (int k = 0; k < 32; k++) begin
            if (v[k]) begin
                b.idx  = k;
                b.rem  = cnt;
                b.last = (cnt == 1) ? 1 : 0;
                q.push_back(b);
                cnt--;
            end
        end
    endtask

    // The monitor samples on the falling edge, half a cycle away from the active edge.
    initial begin
        beat_t h;
        bit    idle_exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("in_ready_in_reset", int'(bus.in_ready), 0);
                q.delete();
            end else begin
                idle_exp = (q.size() == 0);
                check("out_valid", int'(bus.out_valid), idle_exp ? 0 : 1);
                check("in_ready", int'(bus.in_ready), idle_exp ? 1 : 0);
                if (idle_exp) begin
                    check("idle_remain", int'(bus.remain), 0);
                    check("idle_idx", int'(bus.out_idx), 0);
                    check("idle_last", int'(bus.out_last), 0);
                    if (bus.in_valid && bus.in_vec != 32'h0) push_vec(bus.in_vec);
                end else begin
                    h = q[0];
                    check("out_idx", int'(bus.out_idx), h.idx);
                    check("out_last", int'(bus.out_last), h.last);
                    check("remain", int'(bus.remain), h.rem);
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
        end
    end

    // out_ready is driven from this one process.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    task automatic send(input logic [31:0] v);
        int b;
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        b   = 0;
        acc = 1'b0;
        while (!acc && b < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            b++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected accept of %h", v);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_vec   = $urandom;
    endtask

    task automatic wait_idle();
        int b;
        bit done;
        b    = 0;
        done = 1'b0;
        while (!done && b < 300) begin
            @(negedge clk);
            done = bus.in_ready && !bus.out_valid;
            b++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] one;
        one          = 32'h1;
        bus.in_valid = 1'b0;
        bus.in_vec   = 32'h0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_remain", int'(bus.remain), 0);
        check("rst_out_idx", int'(bus.out_idx), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        send(32'h0000_0001);
        wait_idle();
        send(32'h8000_0011);
        wait_idle();

        ready_force = 1'b0;
        send(32'h0000_0300);
        repeat (3) @(posedge clk);
        #1;
        ready_force = 1'b1;
        wait_idle();

        send(32'h0000_0000);
        repeat (2) @(posedge clk);
        #1;
        send(32'hFFFF_FFFF);
        wait_idle();

        send(32'h0000_00F0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 32; k++) send(one << k);
        wait_idle();

        rnd_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       v = $urandom;
                1:       v = $urandom & $urandom & $urandom;
                2:       v = one << $urandom_range(0, 31);
                3:       v = 32'h0;
                default: v = ~($urandom & $urandom);
            endcase
            send(v);
        end
        wait_idle();
        rnd_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
